// File: rtl/mem_op_sequencer_if.sv
// Bus between the transaction requester / RAM / AND-OR unit side and the sequencer.
// The master side drives requests and returns RAM read data and op results.
interface mem_op_sequencer_if #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 3,
  parameter int unsigned CNT_W = 8
) ();
  logic             start;
  logic             or_mode;
  logic [AW-1:0]    a_addr;
  logic [AW-1:0]    b_addr;
  logic [AW-1:0]    c_addr;
  logic             busy;
  logic             done;
  logic [DW-1:0]    result;
  logic [CNT_W-1:0] txn_count;
  logic [AW-1:0]    mem_addr;
  logic             mem_wmode;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata;
  logic             op_mode;
  logic [DW-1:0]    op_a;
  logic [DW-1:0]    op_b;
  logic [DW-1:0]    op_c;

  modport master (
    output start, or_mode, a_addr, b_addr, c_addr, mem_rdata, op_c,
    input  busy, done, result, txn_count, mem_addr, mem_wmode, mem_wdata,
           op_mode, op_a, op_b
  );

  modport slave (
    input  start, or_mode, a_addr, b_addr, c_addr, mem_rdata, op_c,
    output busy, done, result, txn_count, mem_addr, mem_wmode, mem_wdata,
           op_mode, op_a, op_b
  );
endinterface

// File: rtl/mem_op_sequencer.sv
// Sequences one RAM-to-RAM AND/OR transaction: read A, read B, compute, write C, done.
// Owns the RAM address/write controls and the op operands; start/done handshake.
module mem_op_sequencer #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_op_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    EXEC = 3'd3,
    WR_C = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    a_addr_q, b_addr_q, c_addr_q;
  logic             mode_q;
  logic [DW-1:0]    a_q, b_q;
  logic [DW-1:0]    result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, wmode_q;
  logic [AW-1:0]    addr_q;

  logic             latch_en;
  logic [AW-1:0]    addr_d;
  logic             wmode_d, done_d, busy_d;

  // Next state plus next values of the state-decoded outputs, so those outputs come from flops
  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    addr_d   = '0;
    wmode_d  = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = RD_A;
          latch_en = 1'b1;
          addr_d   = bus.a_addr;
        end
      end
      RD_A: begin
        state_d = RD_B;
        addr_d  = b_addr_q;
      end
      RD_B: state_d = EXEC;
      EXEC: begin
        state_d = WR_C;
        addr_d  = c_addr_q;
        wmode_d = 1'b1;
      end
      WR_C: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Reset aborts any in-flight transaction; nothing resumes afterwards
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
      mode_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wmode_q  <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wmode_q <= wmode_d;
      addr_q  <= addr_d;
      if (latch_en) begin
        a_addr_q <= bus.a_addr;
        b_addr_q <= bus.b_addr;
        c_addr_q <= bus.c_addr;
        mode_q   <= bus.or_mode;
      end
      if (state_q == RD_A) a_q <= bus.mem_rdata;
      if (state_q == RD_B) b_q <= bus.mem_rdata;
      if (state_q == WR_C) begin
        result_q <= bus.op_c;
        cnt_q    <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.txn_count = cnt_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wmode = wmode_q;
  assign bus.mem_wdata = bus.op_c;
  assign bus.op_mode   = mode_q;
  assign bus.op_a      = a_q;
  assign bus.op_b      = b_q;

endmodule

// File: tb/tb_mem_op_sequencer.sv
// Directed bench for mem_op_sequencer: RAM and registered AND/OR unit modelled here,
// plus a second instance with a 2-bit counter to exercise counter wrap.
module tb_mem_op_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 3;

  logic clk;
  logic rst;

  mem_op_sequencer_if #(.DW(DW), .AW(AW), .CNT_W(8)) bus  ();
  mem_op_sequencer_if #(.DW(DW), .AW(AW), .CNT_W(2)) bus2 ();

  mem_op_sequencer #(.DW(DW), .AW(AW), .CNT_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  mem_op_sequencer #(.DW(DW), .AW(AW), .CNT_W(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] ram [8];
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: combinational read, write on clk edge; preload port for the bench
  always_ff @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (bus.mem_wmode) ram[bus.mem_addr] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = ram[bus.mem_addr];

  // Registered AND/OR unit, one cycle latency
  always_ff @(posedge clk) begin
    bus.op_c <= bus.op_mode ? (bus.op_a | bus.op_b) : (bus.op_a & bus.op_b);
  end

  assign bus2.mem_rdata = '0;
  assign bus2.op_c      = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  // Runs one transaction; lat = edges from start sample to done observed (0 on timeout)
  task automatic run_txn(input logic mode, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] c, input bit poke, output int lat);
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.or_mode = mode;
    bus.a_addr = a; bus.b_addr = b; bus.c_addr = c;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    n = 0;
    while (n < 12) begin
      if (poke && n == 1) begin
        bus.start = 1'b1; bus.c_addr = 3'd7; bus.or_mode = ~mode;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int done_cnt, wm_cnt, first_done, second_done;
    bit seen;
    logic [1:0] exp_cnt2 [5];

    rst = 1'b0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    bus.start = 1'b0; bus.or_mode = 1'b0;
    bus.a_addr = '0; bus.b_addr = '0; bus.c_addr = '0;
    bus2.start = 1'b0; bus2.or_mode = 1'b0;
    bus2.a_addr = '0; bus2.b_addr = '0; bus2.c_addr = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   64'(bus.busy),      64'd0);
    check("rst_done",   64'(bus.done),      64'd0);
    check("rst_wmode",  64'(bus.mem_wmode), 64'd0);
    check("rst_addr",   64'(bus.mem_addr),  64'd0);
    check("rst_result", 64'(bus.result),    64'd0);
    check("rst_count",  64'(bus.txn_count), 64'd0);
    check("rst_op_a",   64'(bus.op_a),      64'd0);

    preload(3'd1, 32'hF0F0F0F0);
    preload(3'd2, 32'h0FF0FF00);
    preload(3'd5, 32'h0000FFFF);
    preload(3'd6, 32'h00FF00FF);
    preload(3'd7, 32'h12345678);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // AND, fixed latency
    run_txn(1'b0, 3'd1, 3'd2, 3'd3, 1'b0, lat);
    check("and_lat",    64'(lat),           64'd4);
    check("and_ram3",   64'(ram[3]),        64'h00F0F000);
    check("and_result", 64'(bus.result),    64'h00F0F000);
    check("and_count",  64'(bus.txn_count), 64'd1);

    // OR, same operands
    run_txn(1'b1, 3'd1, 3'd2, 3'd3, 1'b0, lat);
    check("or_ram3",    64'(ram[3]),        64'hFFF0FFF0);
    check("or_result",  64'(bus.result),    64'hFFF0FFF0);
    check("or_count",   64'(bus.txn_count), 64'd2);

    // In-place: c == a
    run_txn(1'b1, 3'd5, 3'd6, 3'd5, 1'b0, lat);
    check("inplace_ram5", 64'(ram[5]),      64'h00FFFFFF);

    // a == b
    run_txn(1'b0, 3'd6, 3'd6, 3'd0, 1'b0, lat);
    check("aeqb_ram0",  64'(ram[0]),        64'h00FF00FF);
    check("aeqb_count", 64'(bus.txn_count), 64'd4);

    // Start while busy with different c/mode must be dropped
    run_txn(1'b0, 3'd1, 3'd2, 3'd4, 1'b1, lat);
    check("poke_lat",   64'(lat),           64'd4);
    check("poke_ram4",  64'(ram[4]),        64'h00F0F000);
    check("poke_ram7",  64'(ram[7]),        64'h12345678);
    check("poke_count", 64'(bus.txn_count), 64'd5);
    check("poke_busy",  64'(bus.busy),      64'd0);

    // Start held high: one transaction per 6 cycles
    @(negedge clk);
    bus.start = 1'b1; bus.or_mode = 1'b0;
    bus.a_addr = 3'd5; bus.b_addr = 3'd1; bus.c_addr = 3'd6;
    done_cnt = 0; wm_cnt = 0; first_done = -1; second_done = -1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.mem_wmode) wm_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (first_done < 0) first_done = i;
        else second_done = i;
      end
    end
    bus.start = 1'b0;
    check("held_dones",  64'(done_cnt),      64'd2);
    check("held_wmodes", 64'(wm_cnt),        64'd2);
    check("held_first",  64'(first_done),    64'd4);
    check("held_second", 64'(second_done),   64'd10);
    check("held_ram6",   64'(ram[6]),        64'h00F0F0F0);
    check("held_count",  64'(bus.txn_count), 64'd7);
    @(posedge clk); #1;
    check("held_idle",   64'(bus.busy),      64'd0);

    // Reset during WR_C aborts the write
    @(negedge clk);
    bus.start = 1'b1; bus.or_mode = 1'b0;
    bus.a_addr = 3'd1; bus.b_addr = 3'd2; bus.c_addr = 3'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.mem_wmode) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("arst_reached_wr", 64'(seen), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_wmode",  64'(bus.mem_wmode), 64'd0);
    check("arst_busy",   64'(bus.busy),      64'd0);
    check("arst_count",  64'(bus.txn_count), 64'd0);
    check("arst_result", 64'(bus.result),    64'd0);
    check("arst_addr",   64'(bus.mem_addr),  64'd0);
    check("arst_op_b",   64'(bus.op_b),      64'd0);
    @(posedge clk); #1;
    check("arst_ram3",   64'(ram[3]),        64'hFFF0FFF0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    check("arst_no_resume", 64'(seen),          64'd0);
    check("arst_count2",    64'(bus.txn_count), 64'd0);

    // 2-bit counter wrap on the second instance
    exp_cnt2[0] = 2'd1; exp_cnt2[1] = 2'd2; exp_cnt2[2] = 2'd3;
    exp_cnt2[3] = 2'd0; exp_cnt2[4] = 2'd1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      bus2.start = 1'b1;
      @(posedge clk); #1;
      bus2.start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (bus2.done) begin
          seen = 1'b1;
          break;
        end
      end
      check($sformatf("wrap_done%0d", t),  64'(seen),            64'd1);
      check($sformatf("wrap_count%0d", t), 64'(bus2.txn_count),  64'(exp_cnt2[t]));
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
